// File: rtl/square_share_arbiter.sv
// square_share_arbiter
//   Shares a single DW-bit squaring datapath among NREQ requesters using
//   round-robin arbitration. Each accepted operand is squared and parked,
//   tagged with its requester id, in a single-entry output register that
//   honours backpressure from the consumer.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand valid
//   req_data   packed operands, requester i in bits [i*DW +: DW]
//   req_ready  one-hot grant (combinational)
//   res_valid  output register holds a result
//   res_data   square of the accepted operand, 2*DW bits
//   res_id     requester index that produced res_data
//   res_ready  consumer takes the result this cycle
//   done_cnt   wrapping count of completed result handshakes
module square_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int DW    = 3,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  output logic [2*DW-1:0]     res_data,
  output logic [ID_W-1:0]     res_id,
  input  logic                res_ready,
  output logic [CNT_W-1:0]    done_cnt
);

  // Zero-extend before multiplying so the full 2*DW-bit product is kept.
  function automatic logic [2*DW-1:0] square_f(input logic [DW-1:0] op);
    logic [2*DW-1:0] ext;
    ext = {{DW{1'b0}}, op};
    return ext * ext;
  endfunction

  logic                res_valid_r;
  logic [2*DW-1:0]     res_data_r;
  logic [ID_W-1:0]     res_id_r;
  logic [ID_W-1:0]     last_id_r;
  logic [CNT_W-1:0]    done_cnt_r;

  logic                slot_free_s;
  logic                found_s;
  logic [ID_W-1:0]     winner_s;
  logic [NREQ-1:0]     grant_s;
  logic                accept_s;
  logic                drain_s;
  logic [DW-1:0]       op_s;

  // The output slot can take a new result if empty or being emptied now.
  assign slot_free_s = !res_valid_r | res_ready;
  assign drain_s     = res_valid_r & res_ready;

  // Round-robin search starting just after the last winner, wrapping at NREQ.
  always_comb begin
    int unsigned     sum_v;
    logic [ID_W-1:0] idx_v;
    logic            hit_v;
    found_s  = 1'b0;
    winner_s = '0;
    sum_v    = 0;
    idx_v    = '0;
    hit_v    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      sum_v    = (int'(last_id_r) + k) % NREQ;
      idx_v    = ID_W'(sum_v);
      hit_v    = !found_s && req_valid[idx_v];
      winner_s = hit_v ? idx_v : winner_s;
      found_s  = found_s | hit_v;
    end
  end

  // Grant is withheld during reset and whenever the output slot is blocked.
  always_comb begin
    grant_s = '0;
    if (rst_n && slot_free_s && found_s) begin
      grant_s = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
    end else begin
      grant_s = '0;
    end
  end

  assign req_ready = grant_s;
  assign accept_s  = |(req_valid & grant_s);

  // Operand mux for the winning requester; depends only on the grant index.
  always_comb begin
    op_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_s = op_s | ((winner_s == ID_W'(i)) ? req_data[i*DW +: DW] : {DW{1'b0}});
    end
  end

  // Output register: a new accept overwrites, otherwise a drain empties it
  // while leaving data and id untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_id_r    <= '0;
      last_id_r   <= ID_W'(NREQ - 1);
    end else if (accept_s) begin
      res_valid_r <= 1'b1;
      res_data_r  <= square_f(op_s);
      res_id_r    <= winner_s;
      last_id_r   <= winner_s;
    end else if (drain_s) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

  // Completed-handshake counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_r <= '0;
    end else if (drain_s) begin
      done_cnt_r <= done_cnt_r + CNT_W'(1);
    end else begin
      done_cnt_r <= done_cnt_r;
    end
  end

  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;
  assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_square_share_arbiter.sv
// Directed testbench for square_share_arbiter with hand-computed expectations.
module tb_square_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [11:0] req_data;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [5:0]  res_data;
  logic [1:0]  res_id;
  logic        res_ready;
  logic [7:0]  done_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  // Hand-computed squares of 4,5,6,7 and of 0..7.
  int rr_sq [4] = '{16, 25, 36, 49};
  int all_sq[8] = '{0, 1, 4, 9, 16, 25, 36, 49};

  always #5 clk = ~clk;

  square_share_arbiter #(.NREQ(4), .ID_W(2), .DW(3), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready),
    .done_cnt  (done_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int lane, input logic [2:0] val);
    req_data[lane*3 +: 3] = val;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1. Reset observed before any clock edge.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 12'd0;
    res_ready = 1'b1;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_res_id",    32'(res_id),    32'd0);
    check("rst_done_cnt",  32'(done_cnt),  32'd0);
    step();
    req_valid = 4'b0000;
    rst_n     = 1'b1;

    // 2. Single request from requester 2, operand 7.
    step();
    req_valid = 4'b0100;
    set_op(2, 3'd7);
    #1;
    check("single_ready", 32'(req_ready), 32'd4);
    step();
    req_valid = 4'b0000;
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_data",  32'(res_data),  32'd49);
    check("single_id",    32'(res_id),    32'd2);
    check("single_cnt0",  32'(done_cnt),  32'd0);
    step();
    check("single_cnt1",  32'(done_cnt),  32'd1);
    check("single_drain", 32'(res_valid), 32'd0);

    // 3. Round robin across all four requesters from a fresh pointer.
    pulse_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_op(i, 3'(4 + i));
    #1;
    check("rr_ready0", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      req_valid[i] = 1'b0;
      check($sformatf("rr_valid%0d", i), 32'(res_valid), 32'd1);
      check($sformatf("rr_data%0d", i),  32'(res_data),  32'(rr_sq[i]));
      check($sformatf("rr_id%0d", i),    32'(res_id),    32'(i));
      #1;
      check($sformatf("rr_next_ready%0d", i), 32'(req_ready), (i < 3) ? 32'(1 << (i + 1)) : 32'd0);
    end
    check("rr_cnt", 32'(done_cnt), 32'd3);

    // last_id is 3: with requesters 0 and 1 valid, 0 must win.
    req_valid = 4'b0011;
    set_op(0, 3'd2);
    set_op(1, 3'd3);
    #1;
    check("rr_last_id3", 32'(req_ready), 32'd1);

    // 4. Backpressure with requester 1 waiting.
    step();
    req_valid[0] = 1'b0;
    res_ready    = 1'b0;
    #1;
    check("bp_ready0", 32'(req_ready), 32'd0);
    check("bp_data",   32'(res_data),  32'd4);
    check("bp_id",     32'(res_id),    32'd0);
    check("bp_cnt",    32'(done_cnt),  32'd4);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("bp_hold_valid%0d", c), 32'(res_valid), 32'd1);
      check($sformatf("bp_hold_data%0d", c),  32'(res_data),  32'd4);
      check($sformatf("bp_hold_id%0d", c),    32'(res_id),    32'd0);
      check($sformatf("bp_hold_ready%0d", c), 32'(req_ready), 32'd0);
      check($sformatf("bp_hold_cnt%0d", c),   32'(done_cnt),  32'd4);
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'd2);
    step();
    req_valid = 4'b0000;
    check("bp_nobubble_valid", 32'(res_valid), 32'd1);
    check("bp_new_data",       32'(res_data),  32'd9);
    check("bp_new_id",         32'(res_id),    32'd1);
    check("bp_cnt5",           32'(done_cnt),  32'd5);
    step();
    check("bp_drain_valid", 32'(res_valid), 32'd0);
    check("bp_drain_hold",  32'(res_data),  32'd9);
    check("bp_cnt6",        32'(done_cnt),  32'd6);

    // 5. Exhaustive operands through requester 3, back to back.
    pulse_reset();
    req_valid = 4'b1000;
    for (int v = 0; v < 8; v++) begin
      set_op(3, 3'(v));
      step();
      check($sformatf("ex_data%0d", v),  32'(res_data),    32'(all_sq[v]));
      check($sformatf("ex_bit1_%0d", v), 32'(res_data[1]), 32'd0);
      check($sformatf("ex_id%0d", v),    32'(res_id),      32'd3);
      check($sformatf("ex_valid%0d", v), 32'(res_valid),   32'd1);
    end
    req_valid = 4'b0000;
    step();
    check("ex_cnt",   32'(done_cnt),  32'd8);
    check("ex_drain", 32'(res_valid), 32'd0);

    // 6. Asynchronous reset while a result is pending.
    req_valid = 4'b0010;
    set_op(1, 3'd4);
    step();
    req_valid = 4'b0000;
    check("ar_pending_valid", 32'(res_valid), 32'd1);
    check("ar_pending_data",  32'(res_data),  32'd16);
    rst_n     = 1'b0;
    req_valid = 4'b0101;
    set_op(0, 3'd5);
    set_op(2, 3'd6);
    #1;
    check("ar_valid", 32'(res_valid), 32'd0);
    check("ar_data",  32'(res_data),  32'd0);
    check("ar_id",    32'(res_id),    32'd0);
    check("ar_cnt",   32'(done_cnt),  32'd0);
    check("ar_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ar_first_grant", 32'(req_ready), 32'd1);
    step();
    req_valid[0] = 1'b0;
    check("ar_res0_data", 32'(res_data), 32'd25);
    check("ar_res0_id",   32'(res_id),   32'd0);
    #1;
    check("ar_second_grant", 32'(req_ready), 32'd4);
    step();
    req_valid = 4'b0000;
    check("ar_res2_data", 32'(res_data), 32'd36);
    check("ar_res2_id",   32'(res_id),   32'd2);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
